// File: rtl/imem_loader.sv
// imem_loader: streams MSB-first program bytes into instruction memory.
// Optional end-of-load checksum check is built when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [7:0]  word_count,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset_n,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        checksum_ok
);

  localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic [7:0]  wc_q;
  logic [7:0]  widx;
  logic [1:0]  bcnt;
  logic [23:0] acc;
  logic [31:0] word_in;
  logic        fire;
  logic        idle_like;
  logic        go_zero;
  logic        go_err;
  logic        go_load;
  logic        last_word;
  logic        byte4;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum_q;
  logic        chk_q;
`endif

  assign fire      = byte_valid & byte_ready;
  assign word_in   = {acc, byte_in};
  assign byte4     = fire & (bcnt == 2'd3);
  assign idle_like = (state == S_IDLE) | (state == S_DONE);
  assign go_zero   = idle_like & start & (word_count == 8'd0);
  assign go_err    = idle_like & start & ({24'd0, word_count} > DEPTH_U);
  assign go_load   = idle_like & start & ~go_zero & ~go_err;
  assign last_word = (widx == wc_q - 8'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum_ok = chk_q & done;
`else
  assign checksum_ok = done;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and per-state strobes.
  always_comb begin
    state_n    = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (go_zero)      state_n = S_DONE;
        else if (go_err)  state_n = S_IDLE;
        else if (go_load) state_n = S_RECV;
      end
      S_RECV: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte4) state_n = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (!last_word)
          state_n = S_RECV;
        else
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_n = S_CHECK;
`else
          state_n = S_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte4) state_n = S_DONE;
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, write address/data, status flags.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wc_q        <= '0;
      widx        <= '0;
      bcnt        <= '0;
      acc         <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_reset_n <= 1'b0;
      error       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q       <= '0;
      chk_q       <= 1'b0;
`endif
    end else begin
      if (go_load) begin
        wc_q        <= word_count;
        widx        <= '0;
        bcnt        <= '0;
        acc         <= '0;
        error       <= 1'b0;
        cpu_reset_n <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q       <= '0;
        chk_q       <= 1'b0;
`endif
      end
      if (go_zero) begin
        error <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_q <= 1'b1;
`endif
      end
      if (go_err) begin
        error <= 1'b1;
      end
      if (fire) begin
        acc  <= word_in[23:0];
        bcnt <= bcnt + 2'd1;
      end
      if (byte4 && state == S_RECV) begin
        mem_wdata <= word_in;
        mem_addr  <= {22'd0, widx, 2'b00};
      end
      if (state == S_WRITE) begin
        widx  <= widx + 8'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_q <= sum_q + mem_wdata;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (byte4 && state == S_CHECK) begin
        chk_q <= (word_in == sum_q);
      end
`endif
      if (state_n == S_DONE) begin
        cpu_reset_n <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads, write scoreboard checked by a monitor.
// Checksum cases run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  word_count = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        error;
  logic        checksum_ok;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  fails = 0;
  int  nwr = 0;

  imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk),
    .Reset(Reset),
    .start(start),
    .word_count(word_count),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_reset_n(cpu_reset_n),
    .busy(busy),
    .done(done),
    .error(error),
    .checksum_ok(checksum_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe pops one expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (mem_we === 1'b1) begin
      nwr++;
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected none",
                 mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("write_addr", mem_addr, e.addr);
        chk("write_data", mem_wdata, e.data);
      end
    end
  end

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    sb.push_back('{addr: a, data: d});
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    word_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      checks++;
      fails++;
      $display("FAIL byte_ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_tail(input logic [31:0] s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(s);
`else
    if (s === 32'hx) $display("note: unused checksum");
`endif
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, done, 1'b1);
    chk({name, "_cpu_rst_n"}, cpu_reset_n, 1'b1);
    chk({name, "_busy"}, busy, 1'b0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base;
    logic [31:0] w;
    logic [31:0] s;

    // Reset state
    @(negedge clk);
    do_reset();
    chk("rst_ready", byte_ready, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_cpu", cpu_reset_n, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", error, 1'b0);
    chk("rst_cks", checksum_ok, 1'b0);

    // Two-word load
    expect_wr(32'h0, 32'h2008_0005);
    expect_wr(32'h4, 32'h0000_000C);
    do_start(8'd2);
    chk("t1_busy", busy, 1'b1);
    chk("t1_cpu_low", cpu_reset_n, 1'b0);
    chk("t1_ready", byte_ready, 1'b1);
    send_word(32'h2008_0005);
    send_word(32'h0000_000C);
    send_tail(32'h2008_0011);
    chk("t1_cpu_before_done", cpu_reset_n, done);
    wait_done("t1");
    chk("t1_cks", checksum_ok, 1'b1);
    chk("t1_sb", sb.size(), 0);

    // Zero-word start
    do_reset();
    base = nwr;
    do_start(8'd0);
    chk("t2_done", done, 1'b1);
    chk("t2_cpu", cpu_reset_n, 1'b1);
    chk("t2_busy", busy, 1'b0);
    @(negedge clk);
    chk("t2_nwr", nwr - base, 0);

    // Oversize start
    do_reset();
    base = nwr;
    do_start(8'd65);
    chk("t3_err", error, 1'b1);
    chk("t3_done", done, 1'b0);
    chk("t3_busy", busy, 1'b0);
    chk("t3_ready", byte_ready, 1'b0);
    chk("t3_cpu", cpu_reset_n, 1'b0);
    @(negedge clk);
    chk("t3_nwr", nwr - base, 0);

    // Toggled valid, start pulsed mid-load
    base = nwr;
    expect_wr(32'h0, 32'hDEAD_BEEF);
    do_start(8'd1);
    chk("t4_err_clr", error, 1'b0);
    send_byte(8'hDE);
    @(negedge clk);
    send_byte(8'hAD);
    do_start(8'd0);
    send_byte(8'hBE);
    @(negedge clk);
    send_byte(8'hEF);
    @(negedge clk);
    send_tail(32'hDEAD_BEEF);
    wait_done("t4");
    chk("t4_nwr", nwr - base, 1);
    chk("t4_sb", sb.size(), 0);

    // Reset mid-load after 5 bytes
    do_reset();
    base = nwr;
    expect_wr(32'h0, 32'h1122_3344);
    do_start(8'd3);
    send_word(32'h1122_3344);
    send_byte(8'h55);
    Reset = 1'b1;
    @(negedge clk);
    chk("t5_ready", byte_ready, 1'b0);
    chk("t5_we", mem_we, 1'b0);
    chk("t5_addr", mem_addr, 32'h0);
    chk("t5_wdata", mem_wdata, 32'h0);
    chk("t5_cpu", cpu_reset_n, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_done", done, 1'b0);
    chk("t5_cks", checksum_ok, 1'b0);
    Reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_nwr", nwr - base, 1);
    expect_wr(32'h0, 32'hCAFE_F00D);
    expect_wr(32'h4, 32'h0BAD_BEEF);
    do_start(8'd2);
    send_word(32'hCAFE_F00D);
    send_word(32'h0BAD_BEEF);
    send_tail(32'hD6AC_AEFC);
    wait_done("t5b");
    chk("t5_sb", sb.size(), 0);

    // Full-depth load, last address 4*(DEPTH-1)
    base = nwr;
    s = '0;
    do_start(8'(DEPTH));
    chk("t6_busy", busy, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      w = {i[7:0], 8'hA5, ~i[7:0], 8'h3C};
      s = s + w;
      expect_wr(32'(4 * i), w);
      send_word(w);
    end
    send_tail(s);
    wait_done("t6");
    chk("t6_nwr", nwr - base, DEPTH);
    chk("t6_last_addr", mem_addr, 32'd252);
    chk("t6_sb", sb.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    expect_wr(32'h0, 32'h1);
    expect_wr(32'h4, 32'h2);
    do_start(8'd2);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h3);
    wait_done("t7");
    chk("t7_cks", checksum_ok, 1'b1);
    expect_wr(32'h0, 32'h1);
    expect_wr(32'h4, 32'h2);
    do_start(8'd2);
    chk("t8_cks_clr", checksum_ok, 1'b0);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h4);
    wait_done("t8");
    chk("t8_cks", checksum_ok, 1'b0);
    chk("t8_sb", sb.size(), 0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: instruction memory capacity in 32-bit words.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  load request, sampled in IDLE or DONE only.
REQ-005 word_count  input  8  number of program words to load, latched on an accepted start.
REQ-006 byte_in  input  8  program byte stream, most-significant byte of each word first.
REQ-007 byte_valid  input  1  byte_in is valid.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs on byte_valid and byte_ready.
REQ-009 mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-010 mem_addr  output  32  byte address of the write, always a multiple of 4.
REQ-011 mem_wdata  output  32  assembled instruction word.
REQ-012 cpu_reset_n  output  1  active-low hold for the fetch unit; low while the program is not loaded.
REQ-013 busy, done, error  output  1 each  loading in progress / last load completed / last start rejected.
REQ-014 checksum_ok  output  1  checksum result (see Configuration).

Function
REQ-015 FSM states: IDLE, RECV, WRITE, CHECK, DONE; encoding is free.
REQ-016 IDLE/DONE + start: word_count==0 -> DONE with done=1 and no writes; word_count>DEPTH_WORDS -> IDLE with error=1 and no writes; otherwise -> RECV, with error=0, done=0, word counter=0, byte counter=0, and address=0.
REQ-017 start is ignored in RECV, WRITE, and CHECK.
REQ-018 byte_ready=1 only in RECV (and in CHECK when enabled); it is 0 in all other states.
REQ-019 Byte assembly: the k-th accepted byte of a word (k=0..3) is placed in bits [31-8k:24-8k].
REQ-020 When the 4th byte is accepted, the next cycle is WRITE: mem_we=1, mem_wdata=assembled word, mem_addr=4*word index.
REQ-021 WRITE lasts exactly one cycle. It then goes to RECV if words remain, otherwise to CHECK (macro defined) or DONE.
REQ-022 mem_we is 0 in every state except WRITE; mem_addr and mem_wdata hold their last values outside WRITE.
REQ-023 busy=1 in RECV, WRITE, and CHECK.
REQ-024 cpu_reset_n=0 from reset and from an accepted nonzero start; it goes to 1 in the first cycle of DONE and stays 1 until the next accepted nonzero start or Reset.
REQ-025 done is sticky in DONE and cleared by the next accepted start.
REQ-026 Gaps in byte_valid stall assembly indefinitely with no timeout; the partial word is retained.
REQ-027 The word index wraps never: the maximum address written is 4*(DEPTH_WORDS-1).

Reset
REQ-028 When Reset=1 on a clock edge: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset_n=0, busy=0, done=0, error=0, checksum_ok=0, and all counters and the accumulator=0.
REQ-029 Reset mid-load aborts immediately; no further writes occur, and the partially loaded memory contents are not cleared.
REQ-030 Reset has priority over start and over byte transfers in the same cycle.

Configuration
REQ-031 With macro IMEM_LOADER_CHECKSUM_EN defined, the loader keeps a 32-bit modulo-2^32 sum of all written words; CHECK receives 4 more bytes (same ordering) and sets checksum_ok=1 if they equal the sum, else 0, then enters DONE.
REQ-032 With the macro defined, a checksum mismatch still reaches DONE and releases cpu_reset_n; checksum_ok is valid while done=1.
REQ-033 Without the macro, the CHECK state and the accumulator are absent, checksum_ok=1 whenever done=1 (otherwise 0), and no extra bytes are consumed.

Verification
REQ-034 Reset, start with word_count=2, bytes 20,08,00,05,00,00,00,0C -> writes 0x20080005 at address 0 and 0x0000000C at address 4; done=1; cpu_reset_n rises the first DONE cycle.
REQ-035 start with word_count=0 -> DONE the next cycle, mem_we never asserted, cpu_reset_n=1.
REQ-036 start with word_count=DEPTH_WORDS+1 (65) -> error=1, state IDLE, no writes, cpu_reset_n stays 0.
REQ-037 byte_valid toggled 1/0 every cycle during a 1-word load -> identical write as with a continuous stream; mem_we high exactly one cycle.
REQ-038 Reset asserted after 5 bytes of a 3-word load -> one write only (address 0), all outputs at reset values the next cycle; a new load then proceeds normally.
REQ-039 IMEM_LOADER_CHECKSUM_EN defined, words 0x00000001 and 0x00000002 with checksum bytes 00,00,00,03 -> checksum_ok=1; with checksum bytes 00,00,00,04 -> checksum_ok=0, done=1.
